// File: rtl/mult_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_seq : iterative shift-add MULT/MULTU sequencer with HI/LO result regs
// Revision : 1.0
// ---------------------------------------------------------------------------
module mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             prodv,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] p;
  logic [CNTW-1:0]    cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_mag, b_mag, addend;
  logic [WIDTH:0]     sum;

  // Signed operands are reduced to magnitudes; the sign is restored in FIX.
  assign a_mag  = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag  = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign addend = p[0] ? m : '0;
  assign sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  assign busy  = (state != IDLE);
  assign prodv = ~busy;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = RUN;
      RUN: begin
        if (abort)                  state_nxt = IDLE;
        else if (cnt == LAST_STEP)  state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m   <= '0;
      p   <= '0;
      cnt <= '0;
      neg <= 1'b0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            m   <= a_mag;
            p   <= {{WIDTH{1'b0}}, b_mag};
            neg <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            p   <= {sum, p[WIDTH-1:1]};
            cnt <= cnt + CNTW'(1);
          end
        end
        FIX: begin
          // An abort on this edge leaves the previous result committed.
          if (!abort) begin
            {hi, lo} <= neg ? (~p + (2*WIDTH)'(1)) : p;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult_seq : scoreboard bench for mult_seq, directed corners plus random ops
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_mult_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, sgn, abort;
  logic [W-1:0] a, b;
  logic         busy, prodv;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;   // expected busy cycles, 0 = not checked
  } exp_t;

  exp_t q[$];
  logic [W-1:0] committed_hi, committed_lo;

  mult_seq #(.WIDTH(W), .CNTW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .abort (abort),
    .busy  (busy),
    .prodv (prodv),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference product from plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic logic [63:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    logic [63:0] xe, ye;
    xe = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ye = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  // Monitor: prodv/busy relationship each cycle; result check when busy falls.
  logic prev_busy = 1'b0;
  int   busy_cnt  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) chk("prodv_vs_busy", {63'd0, prodv}, {63'd0, ~busy});
    if (busy === 1'b1) busy_cnt++;
    if (prev_busy && busy === 1'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_completion", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("result_hilo", {hi, lo}, {e.hi, e.lo});
        if (e.cyc != 0) chk("busy_cycles", 64'(busy_cnt), 64'(e.cyc));
      end
      busy_cnt = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic push_exp(input logic [W-1:0] h, input logic [W-1:0] l, input int cyc);
    exp_t e;
    e.hi = h; e.lo = l; e.cyc = cyc;
    q.push_back(e);
  endtask

  // Returns just after the accepting edge (edge 0).
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    @(posedge clk); #1;
    a = x; b = y; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sgn = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy !== 1'b0 || q.size() != 0) && n < 200) begin
      @(posedge clk); n++;
    end
    if (n >= 200) chk("wait_done_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_full(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [63:0] pr;
    pr = ref_prod(x, y, s);
    push_exp(pr[63:32], pr[31:0], W + 1);
    committed_hi = pr[63:32]; committed_lo = pr[31:0];
    start_op(x, y, s);
    wait_done();
  endtask

  // Abort lands on edge k (1..W+1) after acceptance; the old result must survive.
  task automatic run_abort(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           input int k);
    push_exp(committed_hi, committed_lo, k);
    start_op(x, y, s);
    repeat (k - 1) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sgn = 1'b0; abort = 1'b0; a = '0; b = '0;
    committed_hi = '0; committed_lo = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy",  {63'd0, busy},  64'd0);
    chk("reset_prodv", {63'd0, prodv}, 64'd1);
    chk("reset_hilo",  {hi, lo},       64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_hilo", {hi, lo},      64'd0);

    // Directed corners with literal expectations.
    push_exp(32'hFFFF_FFFE, 32'h0000_0001, 33);
    committed_hi = 32'hFFFF_FFFE; committed_lo = 32'h0000_0001;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done();
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    start_op(32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done();
    push_exp(32'h0000_0006, 32'hFFFF_FFEB, 33);
    start_op(32'hFFFF_FFFD, 32'd7, 1'b0);
    wait_done();
    push_exp(32'h4000_0000, 32'h0000_0000, 33);
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done();
    push_exp(32'hFFFF_FFFF, 32'h8000_0000, 33);
    start_op(32'h8000_0000, 32'd1, 1'b1);
    wait_done();

    // Complete 5*6, then abort 9*9 at step 10 with an ignored start at step 5.
    run_full(32'd5, 32'd6, 1'b0);
    push_exp(32'd0, 32'd30, 10);
    start_op(32'd9, 32'd9, 1'b0);
    repeat (4) @(posedge clk);
    #1 begin start = 1'b1; a = 32'd100; b = 32'd100; end
    if (busy) $display("protocol note: start issued while busy (expected to be ignored)");
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_busy",  {63'd0, busy},  64'd0);
    chk("abort_prodv", {63'd0, prodv}, 64'd1);
    chk("abort_hilo",  {hi, lo},       {32'd0, 32'd30});
    wait_done();

    // Reset at step 20 wipes the committed result.
    push_exp(32'd0, 32'd0, 20);
    start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("midreset_prodv", {63'd0, prodv}, 64'd1);
    chk("midreset_hilo",  {hi, lo},       64'd0);
    committed_hi = '0; committed_lo = '0;
    wait_done();
    run_full(32'd2, 32'd3, 1'b0);

    // Randomised operands, with occasional aborts including one on the FIX edge.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      logic         s;
      x = $urandom; y = $urandom; s = 1'($urandom);
      case ($urandom_range(0, 5))
        0: x = 32'h8000_0000;
        1: y = '0;
        2: x = 32'hFFFF_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0)
        run_abort(x, y, s, (i % 7 == 0) ? W + 1 : int'($urandom_range(1, W)));
      else
        run_full(x, y, s);
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Iterative shift-add multiply sequencer serving the MIPS pipeline's MULT/MULTU instructions.
- Accepts a start pulse from the EX stage with two 32-bit operands and a signedness flag.
- Runs one partial-product step per cycle and writes the 64-bit result into internal HI/LO registers.
- Drives busy/prodv so the hazard unit can stall dependent MFHI/MFLO and later multiplies.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each, product is 2*WIDTH bits.
- CNTW, 6, step-counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  multiply request (multstarte), sampled only in IDLE
- sgn  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start
- a  input  WIDTH  multiplicand (rs value after forwarding)
- b  input  WIDTH  multiplier (rt value after forwarding)
- abort  input  1  cancel in-flight multiply (pipeline flush)
- busy  output  1  multiply in progress
- prodv  output  1  HI/LO hold a valid, committed result (prodve)
- hi  output  WIDTH  upper half of the last committed product
- lo  output  WIDTH  lower half of the last committed product

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: state=IDLE, busy=0, prodv=1, hi=0, lo=0, counter=0, neg flag=0. Reset mid-operation drops all work in progress.
- FSM states: IDLE, RUN, FIX. busy=1 in RUN and FIX, 0 in IDLE; prodv=~busy.
- IDLE, start=1 and abort=0 at an edge:
  - Latch M = (sgn & a[WIDTH-1]) ? -a : a, and P = {WIDTH'b0, (sgn & b[WIDTH-1]) ? -b : b}.
  - neg = sgn & (a[WIDTH-1] ^ b[WIDTH-1]); counter=0; go to RUN.
  - Magnitudes are WIDTH-bit unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
- RUN, each edge:
  - {c, s} = P[2W-1:W] + (P[0] ? M : 0), a (WIDTH+1)-bit sum.
  - P <= {c, s, P[W-1:1]}; counter++.
  - On the edge where counter reaches WIDTH-1 (the WIDTH-th step), go to FIX.
- FIX, one edge: {hi, lo} <= neg ? -P (2W-bit two's complement) : P; go to IDLE.
- Latency: start accepted at edge 0, RUN steps at edges 1..WIDTH, HI/LO written at edge WIDTH+1. busy is high for WIDTH+1 cycles; prodv=1 from the cycle after edge WIDTH+1.
- start while busy is ignored (no queueing). The hazard unit is required to stall, so the bench flags it as a protocol error but the DUT stays unaffected.
- abort=1 in RUN or FIX: go to IDLE at that edge, hi/lo unchanged (previous result preserved), prodv=1 next cycle.
- abort and start together in IDLE: abort wins, start is dropped.
- a and b are only sampled on the accepting edge; later changes have no effect.
- hi/lo change only at FIX or reset; never partially visible.
- Zero operands: no early termination; latency is always WIDTH+1.

Test Plan:
- Reset: assert reset 2 cycles -> busy=0, prodv=1, hi=0, lo=0; hold start=0 for 10 cycles -> outputs unchanged.
- Unsigned max: sgn=0, a=b=0xFFFFFFFF, start 1 cycle -> busy=1 for exactly 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, prodv=1.
- Signed mixed: sgn=1, a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then sgn=0 with same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- Signed corner: sgn=1, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Abort/ignore: complete 5*6 (lo=30); start 9*9, pulse start again at step 5 (ignored), abort at step 10 -> next cycle busy=0, prodv=1, lo=30, hi=0.
- Reset mid-run: start 0x12345678*0x9ABCDEF0, assert reset at step 20 -> next cycle hi=lo=0, prodv=1; a following 2*3 completes normally (lo=6) after 33 cycles.
